// File: rtl/udp_tx_chksum_stream_if.sv
// Header type and the header+payload stream bundle used on both sides of the
// TX UDP checksum formatter.
package udp_tx_chksum_stream_pkg;
    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] chksum;
    } udp_pkt_hdr;
endpackage

interface udp_tx_chksum_stream_if #(
    parameter int DATA_WIDTH = 256,
    parameter int PADBYTES_W = 5
);
    import udp_tx_chksum_stream_pkg::*;

    logic                  hdr_val;
    logic [31:0]           src_ip;
    logic [31:0]           dst_ip;
    udp_pkt_hdr            udp_hdr;
    logic                  hdr_rdy;
    logic                  data_val;
    logic                  data_rdy;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [PADBYTES_W-1:0] padbytes;

    modport master (
        output hdr_val, src_ip, dst_ip, udp_hdr, data_val, data, last, padbytes,
        input  hdr_rdy, data_rdy
    );
    modport slave (
        input  hdr_val, src_ip, dst_ip, udp_hdr, data_val, data, last, padbytes,
        output hdr_rdy, data_rdy
    );
endinterface

// File: rtl/udp_tx_chksum_stream.sv
// TX UDP formatter: buffers a whole payload while summing the pseudo-header,
// UDP header and payload, then emits the header with checksum and replays the payload.
module udp_tx_chksum_stream
    import udp_tx_chksum_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = 256,
    parameter int PADBYTES_W      = 5,
    parameter int FIFO_LOG2_DEPTH = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    udp_tx_chksum_stream_if.slave  src,
    udp_tx_chksum_stream_if.master dst
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int WORDS  = DATA_WIDTH / 16;
    localparam int FIFO_W = DATA_WIDTH + 1 + PADBYTES_W;
    localparam int DEPTH  = 1 << FIFO_LOG2_DEPTH;
    localparam logic [FIFO_LOG2_DEPTH:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, ACCUM, FOLD, OUT_HDR, OUT_DATA} state_t;
    state_t state_reg, state_next;

    logic                     out_en_reg;
    logic [31:0]              acc_reg;
    logic                     fold_cnt_reg;
    logic [31:0]              src_ip_reg;
    logic [31:0]              dst_ip_reg;
    udp_pkt_hdr               hdr_reg;
    logic [FIFO_LOG2_DEPTH:0] wr_ptr_reg;
    logic [FIFO_LOG2_DEPTH:0] rd_ptr_reg;
    logic                     head_val_reg;
    logic [FIFO_W-1:0]        head_reg;
    logic [FIFO_W-1:0]        mem [DEPTH];

    logic                  hdr_fire, beat_fire, pop, rd_en;
    logic                  fifo_full, fifo_empty, head_last;
    logic [DATA_WIDTH-1:0] masked_data;
    logic [15:0]           word [WORDS];
    logic [31:0]           beat_sum, seed;
    logic [16:0]           fold_sum;
    logic [15:0]           inv_sum, csum;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[FIFO_LOG2_DEPTH] != rd_ptr_reg[FIFO_LOG2_DEPTH]) &&
                        (wr_ptr_reg[FIFO_LOG2_DEPTH-1:0] == rd_ptr_reg[FIFO_LOG2_DEPTH-1:0]);

    // out_en_reg keeps the source ready low until reset release has been seen by clk
    assign src.hdr_rdy  = out_en_reg && (state_reg == IDLE);
    assign src.data_rdy = (state_reg == ACCUM) && !fifo_full;
    assign hdr_fire     = src.hdr_val && src.hdr_rdy;
    assign beat_fire    = src.data_val && src.data_rdy;

    // Trailing pad bytes of the last beat contribute zero to the sum
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
            logic keep;
            assign keep = !src.last || ((gi + int'(src.padbytes)) < BYTES);
            assign masked_data[DATA_WIDTH-1-8*gi -: 8] =
                keep ? src.data[DATA_WIDTH-1-8*gi -: 8] : 8'h00;
        end
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign word[gi] = masked_data[DATA_WIDTH-1-16*gi -: 16];
        end
    endgenerate

    always_comb begin
        beat_sum = 32'd0;
        for (int i = 0; i < WORDS; i++) begin
            beat_sum = beat_sum + {16'd0, word[i]};
        end
    end

    assign seed = {16'd0, src.src_ip[31:16]} + {16'd0, src.src_ip[15:0]} +
                  {16'd0, src.dst_ip[31:16]} + {16'd0, src.dst_ip[15:0]} +
                  32'h0000_0011 + {16'd0, src.udp_hdr.length} +
                  {16'd0, src.udp_hdr.src_port} + {16'd0, src.udp_hdr.dst_port} +
                  {16'd0, src.udp_hdr.length};

    // A transmitted zero means "no checksum" in UDP, so all-zero becomes all-ones
    assign fold_sum = {1'b0, acc_reg[15:0]} + {1'b0, acc_reg[31:16]};
    assign inv_sum  = ~fold_sum[15:0];
    assign csum     = (inv_sum == 16'd0) ? 16'hFFFF : inv_sum;

    assign head_last = head_reg[PADBYTES_W];
    assign pop       = dst.data_val && dst.data_rdy;
    assign rd_en     = ((state_reg == OUT_HDR) || (state_reg == OUT_DATA)) &&
                       !fifo_empty && (!head_val_reg || pop);

    assign dst.hdr_val  = (state_reg == OUT_HDR);
    assign dst.src_ip   = src_ip_reg;
    assign dst.dst_ip   = dst_ip_reg;
    assign dst.udp_hdr  = hdr_reg;
    assign dst.data_val = (state_reg == OUT_DATA) && head_val_reg;
    assign dst.data     = head_reg[FIFO_W-1 -: DATA_WIDTH];
    assign dst.last     = head_last;
    assign dst.padbytes = head_reg[PADBYTES_W-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (hdr_fire) state_next = ACCUM;
            ACCUM:    if (beat_fire && src.last) state_next = FOLD;
            FOLD:     if (fold_cnt_reg) state_next = OUT_HDR;
            OUT_HDR:  if (dst.hdr_rdy) state_next = OUT_DATA;
            OUT_DATA: if (pop && head_last) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_en_reg   <= 1'b0;
            acc_reg      <= 32'd0;
            fold_cnt_reg <= 1'b0;
            src_ip_reg   <= 32'd0;
            dst_ip_reg   <= 32'd0;
            hdr_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            head_val_reg <= 1'b0;
        end else begin
            out_en_reg <= 1'b1;
            if (hdr_fire) begin
                src_ip_reg     <= src.src_ip;
                dst_ip_reg     <= src.dst_ip;
                hdr_reg        <= src.udp_hdr;
                hdr_reg.chksum <= 16'd0;
                acc_reg        <= seed;
            end
            if (beat_fire) begin
                acc_reg    <= acc_reg + beat_sum;
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (state_reg == FOLD) begin
                fold_cnt_reg <= !fold_cnt_reg;
                acc_reg      <= {15'd0, fold_sum};
                if (fold_cnt_reg) hdr_reg.chksum <= csum;
            end
            if (rd_en) begin
                rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
                head_val_reg <= 1'b1;
            end else if (pop) begin
                head_val_reg <= 1'b0;
            end
        end
    end

    // Payload store: plain array with registered read so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (beat_fire) mem[wr_ptr_reg[FIFO_LOG2_DEPTH-1:0]] <= {src.data, src.last, src.padbytes};
        if (rd_en)     head_reg <= mem[rd_ptr_reg[FIFO_LOG2_DEPTH-1:0]];
    end
endmodule

// File: tb/tb_udp_tx_chksum_stream.sv
// Directed bench for udp_tx_chksum_stream: hand-computed checksums, stall and
// reset scenarios, one line per packet transaction.
module tb_udp_tx_chksum_stream;
    import udp_tx_chksum_stream_pkg::*;

    localparam int DW = 256;
    localparam int PW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    udp_tx_chksum_stream_if #(.DATA_WIDTH(DW), .PADBYTES_W(PW)) src_if ();
    udp_tx_chksum_stream_if #(.DATA_WIDTH(DW), .PADBYTES_W(PW)) dst_if ();

    udp_tx_chksum_stream #(.DATA_WIDTH(DW), .PADBYTES_W(PW), .FIFO_LOG2_DEPTH(11)) dut (
        .clk (clk),
        .rst (rst),
        .src (src_if.slave),
        .dst (dst_if.master)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] pkt_data [4];
    logic [PW-1:0] pkt_pad  [4];
    int            pkt_beats;
    logic [31:0]   pkt_sip, pkt_dip;
    logic [15:0]   pkt_sport, pkt_dport, pkt_len;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic init_pins();
        src_if.hdr_val  = 1'b0;
        src_if.src_ip   = 32'd0;
        src_if.dst_ip   = 32'd0;
        src_if.udp_hdr  = '0;
        src_if.data_val = 1'b0;
        src_if.data     = '0;
        src_if.last     = 1'b0;
        src_if.padbytes = '0;
        dst_if.hdr_rdy  = 1'b0;
        dst_if.data_rdy = 1'b0;
    endtask

    task automatic load_hdr(input logic [15:0] len);
        pkt_sip   = 32'h0A00_0001;
        pkt_dip   = 32'h0A00_0002;
        pkt_sport = 16'h1234;
        pkt_dport = 16'h5678;
        pkt_len   = len;
    endtask

    task automatic load_multi();
        load_hdr(16'd100);
        pkt_beats = 4;
        for (int b = 0; b < 4; b++) begin
            pkt_data[b] = {32{8'hEE}};
            pkt_pad[b]  = 5'd0;
        end
        for (int i = 0; i < 100; i++) pkt_data[i / 32][DW-1-8*(i % 32) -: 8] = 8'(i);
        pkt_pad[3] = 5'd28;
    endtask

    task automatic send_pkt(input int n_send);
        int t;
        int lat;
        src_if.hdr_val  = 1'b1;
        src_if.src_ip   = pkt_sip;
        src_if.dst_ip   = pkt_dip;
        src_if.udp_hdr  = '{src_port: pkt_sport, dst_port: pkt_dport, length: pkt_len, chksum: 16'hDEAD};
        t = 0;
        while (src_if.hdr_rdy !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) begin
            checks++; failures++;
            $display("FAIL src_hdr_rdy_timeout got=%b want=1", src_if.hdr_rdy);
        end
        @(posedge clk); #1;
        src_if.hdr_val = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            src_if.data_val = 1'b1;
            src_if.data     = pkt_data[i];
            src_if.last     = (i == pkt_beats - 1);
            src_if.padbytes = pkt_pad[i];
            t = 0;
            while (src_if.data_rdy !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) begin
                checks++; failures++;
                $display("FAIL src_data_rdy_timeout beat=%0d got=%b want=1", i, src_if.data_rdy);
            end
            @(posedge clk); #1;
        end
        src_if.data_val = 1'b0;
        src_if.last     = 1'b0;
        if (n_send == pkt_beats) begin
            lat = 1;
            while (dst_if.hdr_val !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
            checks++;
            if (lat < 3 || lat >= 20) begin
                failures++;
                $display("FAIL hdr_latency got=%0d cycles want>=3 and <20", lat);
            end
        end
    endtask

    task automatic recv_pkt(input string name, input logic [15:0] exp_csum,
                            input int hdr_stall, input bit toggle);
        int t;
        int idx;
        bit rdy;
        t = 0;
        while (dst_if.hdr_val !== 1'b1 && t < 50) begin
            checks++;
            if (dst_if.data_val !== 1'b0) begin
                failures++;
                $display("FAIL %s data_before_hdr got=%b want=0", name, dst_if.data_val);
            end
            @(posedge clk); #1; t++;
        end
        if (t >= 50) begin
            checks++; failures++;
            $display("FAIL %s dst_hdr_val_timeout got=%b want=1", name, dst_if.hdr_val);
        end
        for (int s = 0; s < hdr_stall; s++) begin
            checks++;
            if (dst_if.hdr_val !== 1'b1 || dst_if.udp_hdr.chksum !== exp_csum ||
                dst_if.udp_hdr.length !== pkt_len || dst_if.src_ip !== pkt_sip) begin
                failures++;
                $display("FAIL %s hdr_stall_stable cyc=%0d val=%b csum=%h want val=1 csum=%h",
                         name, s, dst_if.hdr_val, dst_if.udp_hdr.chksum, exp_csum);
            end
            checks++;
            if (dst_if.data_val !== 1'b0 || src_if.hdr_rdy !== 1'b0) begin
                failures++;
                $display("FAIL %s stall_idle data_val=%b src_hdr_rdy=%b want 0/0",
                         name, dst_if.data_val, src_if.hdr_rdy);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (dst_if.udp_hdr.chksum !== exp_csum) begin
            failures++;
            $display("FAIL %s chksum got=%h want=%h", name, dst_if.udp_hdr.chksum, exp_csum);
        end
        checks++;
        if (dst_if.udp_hdr.length !== pkt_len || dst_if.udp_hdr.src_port !== pkt_sport ||
            dst_if.udp_hdr.dst_port !== pkt_dport) begin
            failures++;
            $display("FAIL %s hdr_fields got=%h/%h/%h want=%h/%h/%h", name, dst_if.udp_hdr.src_port,
                     dst_if.udp_hdr.dst_port, dst_if.udp_hdr.length, pkt_sport, pkt_dport, pkt_len);
        end
        checks++;
        if (dst_if.src_ip !== pkt_sip || dst_if.dst_ip !== pkt_dip) begin
            failures++;
            $display("FAIL %s ips got=%h/%h want=%h/%h", name, dst_if.src_ip, dst_if.dst_ip, pkt_sip, pkt_dip);
        end
        dst_if.hdr_rdy = 1'b1;
        @(posedge clk); #1;
        dst_if.hdr_rdy = 1'b0;
        idx = 0;
        t   = 0;
        rdy = 1'b1;
        while (idx < pkt_beats && t < 200) begin
            dst_if.data_rdy = rdy;
            if (dst_if.data_val === 1'b1 && rdy) begin
                checks++;
                if (dst_if.data !== pkt_data[idx] || dst_if.padbytes !== pkt_pad[idx] ||
                    dst_if.last !== (idx == pkt_beats - 1)) begin
                    failures++;
                    $display("FAIL %s beat%0d got=%h pad=%0d last=%b want=%h pad=%0d", name, idx,
                             dst_if.data, dst_if.padbytes, dst_if.last, pkt_data[idx], pkt_pad[idx]);
                end
                checks++;
                if (src_if.hdr_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s src_hdr_rdy_early got=%b want=0", name, src_if.hdr_rdy);
                end
                idx++;
            end
            @(posedge clk); #1; t++;
            if (toggle) rdy = !rdy;
        end
        dst_if.data_rdy = 1'b0;
        if (idx < pkt_beats) begin
            checks++; failures++;
            $display("FAIL %s data_timeout got=%0d beats want=%0d", name, idx, pkt_beats);
        end
        checks++;
        if (src_if.hdr_rdy !== 1'b1 || dst_if.data_val !== 1'b0) begin
            failures++;
            $display("FAIL %s post_pkt src_hdr_rdy=%b data_val=%b want 1/0", name, src_if.hdr_rdy, dst_if.data_val);
        end
        $display("pkt %s csum=%h beats=%0d", name, dst_if.udp_hdr.chksum, idx);
    endtask

    task automatic test_reset();
        init_pins();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (src_if.hdr_rdy !== 1'b0 || src_if.data_rdy !== 1'b0 ||
            dst_if.hdr_val !== 1'b0 || dst_if.data_val !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdys_vals got=%b%b%b%b want=0000", src_if.hdr_rdy,
                     src_if.data_rdy, dst_if.hdr_val, dst_if.data_val);
        end
        checks++;
        if (dst_if.udp_hdr !== 64'd0 || dst_if.src_ip !== 32'd0 || dst_if.dst_ip !== 32'd0) begin
            failures++;
            $display("FAIL reset_hdr_regs got=%h %h %h want=0", dst_if.udp_hdr, dst_if.src_ip, dst_if.dst_ip);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (src_if.hdr_rdy !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_hdr_rdy got=%b want=1", src_if.hdr_rdy);
        end
        $display("reset done");
    endtask

    task automatic test_even();
        load_hdr(16'd10);
        pkt_beats   = 1;
        pkt_data[0] = {16'hABCD, {30{8'h55}}};
        pkt_pad[0]  = 5'd30;
        send_pkt(1);
        recv_pkt("even", 16'hD75D, 0, 1'b0);
    endtask

    task automatic test_odd();
        load_hdr(16'd9);
        pkt_beats   = 1;
        pkt_data[0] = {8'hAB, {31{8'hCD}}};
        pkt_pad[0]  = 5'd31;
        send_pkt(1);
        recv_pkt("odd", 16'hD82C, 0, 1'b0);
    endtask

    task automatic test_multi();
        load_multi();
        send_pkt(4);
        recv_pkt("multi", 16'hE6A9, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        load_multi();
        send_pkt(4);
        recv_pkt("backpressure", 16'hE6A9, 10, 1'b1);
    endtask

    task automatic test_zero_sum();
        load_hdr(16'd10);
        pkt_beats   = 1;
        pkt_data[0] = {16'h832B, {30{8'h77}}};
        pkt_pad[0]  = 5'd30;
        send_pkt(1);
        recv_pkt("zero_sum", 16'hFFFF, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_multi();
        send_pkt(2);
        rst = 1'b0;
        #1;
        checks++;
        if (src_if.hdr_rdy !== 1'b0 || src_if.data_rdy !== 1'b0 ||
            dst_if.hdr_val !== 1'b0 || dst_if.data_val !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_vals got=%b%b%b%b want=0000", src_if.hdr_rdy,
                     src_if.data_rdy, dst_if.hdr_val, dst_if.data_val);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        $display("mid-packet reset done");
        test_even();
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_multi();
        test_backpressure();
        test_zero_sum();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
